// File: rtl/cache_pkg.sv
// Shared state encoding, default cache geometry and the victim-pick helper.
// No timing of its own; pure types, constants and a combinational function.
package cache_pkg;

  typedef enum logic [1:0] {IDLE, LOOKUP, FILL, WRITE} cache_state_e;

  localparam int DEF_WAYS     = 4;
  localparam int DEF_SET_BITS = 7;
  localparam int DEF_ADDR_W   = 17;
  localparam int DEF_DATA_W   = 32;
  localparam int TAG_W        = DEF_ADDR_W - DEF_SET_BITS;
  localparam int MAX_WAYS     = 8;

  // Onehot of the lowest clear bit; callers pad unused upper ways with ones.
  function automatic logic [MAX_WAYS-1:0] onehot_lowest_zero(input logic [MAX_WAYS-1:0] v);
    return ~v & (v + MAX_WAYS'(1));
  endfunction

endpackage

// File: rtl/cache_way_array.sv
// One cache way: reset-cleared valid bits plus unreset tag/data arrays.
// Combinational read of the addressed set, synchronous write; no backpressure.
module cache_way_array
  import cache_pkg::*;
#(
  parameter int SET_BITS = DEF_SET_BITS,
  parameter int TAG_BITS = TAG_W,
  parameter int DATA_W   = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SET_BITS-1:0] set_idx,
  input  logic                we,
  input  logic [TAG_BITS-1:0] wtag,
  input  logic [DATA_W-1:0]   wdata,
  output logic                rd_valid,
  output logic [TAG_BITS-1:0] rd_tag,
  output logic [DATA_W-1:0]   rd_data
);

  localparam int NSETS = 1 << SET_BITS;

  logic [NSETS-1:0]    valid_q, valid_d;
  logic [TAG_BITS-1:0] tag_mem  [NSETS];
  logic [DATA_W-1:0]   data_mem [NSETS];

  always_comb begin
    valid_d = valid_q;
    if (we) valid_d[set_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[set_idx]  <= wtag;
      data_mem[set_idx] <= wdata;
    end
  end

  assign rd_valid = valid_q[set_idx];
  assign rd_tag   = tag_mem[set_idx];
  assign rd_data  = data_mem[set_idx];

endmodule

// File: rtl/cache_nway_ctrl.sv
// N-way write-through, no-write-allocate cache; read hit 2 cycles, misses/writes wait on sram_ready.
// CPU stalls until the one-cycle cpu_ready pulse; CACHE_PERF_CNT_EN adds hit/miss counters.
module cache_nway_ctrl
  import cache_pkg::*;
#(
  parameter int WAYS     = DEF_WAYS,
  parameter int SET_BITS = DEF_SET_BITS,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              sram_rd,
  output logic              sram_wr,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              sram_ready,
  output logic              hit
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int TAG_BITS = ADDR_W - SET_BITS;
  localparam int NSETS    = 1 << SET_BITS;

  cache_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              is_wr_q, is_wr_d;
  logic              sram_rd_q, sram_rd_d;
  logic              sram_wr_q, sram_wr_d;
  logic [WAYS-1:0]   mru_q [NSETS];

  logic [SET_BITS-1:0] set_idx;
  logic [TAG_BITS-1:0] tag;
  logic [WAYS-1:0]     way_valid, hit_way, victim, way_we, acc_way, mru_cur, mru_nxt;
  logic [TAG_BITS-1:0] way_tag  [WAYS];
  logic [DATA_W-1:0]   way_data [WAYS];
  logic [DATA_W-1:0]   way_wdata, hit_data;
  logic [MAX_WAYS-1:0] vpad, mpad, vsel_v, vsel_m;
  logic                in_lookup, any_hit, fill_done, write_done, mru_we;

  assign set_idx = addr_q[SET_BITS-1:0];
  assign tag     = addr_q[ADDR_W-1:SET_BITS];
  assign mru_cur = mru_q[set_idx];

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    cache_way_array #(
      .SET_BITS(SET_BITS),
      .TAG_BITS(TAG_BITS),
      .DATA_W  (DATA_W)
    ) u_way (
      .clk     (clk),
      .rst_n   (rst_n),
      .set_idx (set_idx),
      .we      (way_we[g]),
      .wtag    (tag),
      .wdata   (way_wdata),
      .rd_valid(way_valid[g]),
      .rd_tag  (way_tag[g]),
      .rd_data (way_data[g])
    );
    assign hit_way[g] = way_valid[g] && (way_tag[g] == tag);
  end

  // Invalid ways win; otherwise the MRU invariant guarantees a clear bit.
  always_comb begin
    vpad = '1;
    mpad = '1;
    vpad[WAYS-1:0] = way_valid;
    mpad[WAYS-1:0] = mru_cur;
    vsel_v = onehot_lowest_zero(vpad);
    vsel_m = onehot_lowest_zero(mpad);
    victim = (&way_valid) ? vsel_m[WAYS-1:0] : vsel_v[WAYS-1:0];
  end

  always_comb begin
    hit_data = '0;
    for (int i = 0; i < WAYS; i++) begin
      hit_data = hit_data | (way_data[i] & {DATA_W{hit_way[i]}});
    end
  end

  always_comb begin
    in_lookup  = (state_q == LOOKUP);
    any_hit    = |hit_way;
    fill_done  = (state_q == FILL) && sram_ready;
    write_done = (state_q == WRITE) && sram_ready;
    hit        = in_lookup && any_hit;
    cpu_ready  = (hit && !is_wr_q) || fill_done || write_done;
    cpu_rdata  = '0;
    if (hit && !is_wr_q) cpu_rdata = hit_data;
    else if (fill_done)  cpu_rdata = sram_rdata;
    way_wdata = fill_done ? sram_rdata : wdata_q;
    way_we    = '0;
    if (in_lookup && is_wr_q) way_we = hit_way;
    if (fill_done)            way_we = victim;
    acc_way = in_lookup ? hit_way : victim;
    mru_we  = hit || fill_done;
    // Saturating the MRU set restarts the history with only the accessed way.
    mru_nxt = mru_cur | acc_way;
    if (&mru_nxt) mru_nxt = acc_way;
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    is_wr_d   = is_wr_q;
    sram_rd_d = sram_rd_q;
    sram_wr_d = sram_wr_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_rd || cpu_wr) begin
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          is_wr_d = cpu_wr;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (is_wr_q) begin
          state_d   = WRITE;
          sram_wr_d = 1'b1;
        end else if (any_hit) begin
          state_d = IDLE;
        end else begin
          state_d   = FILL;
          sram_rd_d = 1'b1;
        end
      end
      FILL: begin
        if (sram_ready) begin
          state_d   = IDLE;
          sram_rd_d = 1'b0;
        end
      end
      WRITE: begin
        if (sram_ready) begin
          state_d   = IDLE;
          sram_wr_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      is_wr_q   <= 1'b0;
      sram_rd_q <= 1'b0;
      sram_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      is_wr_q   <= is_wr_d;
      sram_rd_q <= sram_rd_d;
      sram_wr_q <= sram_wr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NSETS; s++) mru_q[s] <= '0;
    end else if (mru_we) begin
      mru_q[set_idx] <= mru_nxt;
    end
  end

  assign sram_rd    = sram_rd_q;
  assign sram_wr    = sram_wr_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;

`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q + {31'd0, hit};
    miss_cnt_d = miss_cnt_q + {31'd0, in_lookup && !any_hit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_nway_ctrl.sv
// Directed bench for cache_nway_ctrl (default geometry: 4 ways, 7 set bits, 17-bit address).
// Inputs driven and outputs sampled just after the rising edge; SRAM is a scripted responder.
module tb_cache_nway_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [16:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        sram_rd, sram_wr;
  logic [16:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata = '0;
  logic        sram_ready = 1'b0;
  logic        hit;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  int errors = 0;
  int checks = 0;

  cache_nway_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .sram_rd   (sram_rd),
    .sram_wr   (sram_wr),
    .sram_addr (sram_addr),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata),
    .sram_ready(sram_ready),
    .hit       (hit)
`ifdef CACHE_PERF_CNT_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tg, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tg, got, exp);
    end
  endtask

  // One CPU transaction; SRAM answers on the lat-th cycle its request is seen.
  task automatic do_op(input bit wr, input logic [16:0] a, input logic [31:0] wd,
                       input logic [31:0] srd, input int lat, input bit drop,
                       output logic [31:0] rdata, output int cyc, output int rc,
                       output int wc, output bit hit_seen,
                       output logic [16:0] ma, output logic [31:0] mw);
    bit done = 1'b0;
    @(negedge clk);
    cpu_rd = !wr; cpu_wr = wr; cpu_addr = a; cpu_wdata = wd;
    cyc = 0; rc = 0; wc = 0; hit_seen = 1'b0; rdata = '0; ma = '0; mw = '0;
    while (!done && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) hit_seen = hit;
      if (drop && cyc == 1) begin cpu_rd = 1'b0; cpu_wr = 1'b0; end
      if (sram_rd || sram_wr) begin
        if (sram_rd) rc++;
        if (sram_wr) wc++;
        ma = sram_addr; mw = sram_wdata;
        if (rc + wc == lat) begin sram_ready = 1'b1; sram_rdata = srd; end
      end
      #1;
      if (cpu_ready) begin rdata = cpu_rdata; done = 1'b1; end
    end
    check_eq("op_done", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    cpu_rd = 1'b0; cpu_wr = 1'b0; sram_ready = 1'b0; sram_rdata = '0;
  endtask

  task automatic read_chk(input string tg, input logic [16:0] a, input logic [31:0] srd,
                          input bit exp_hit, input logic [31:0] exp_data);
    logic [31:0] rd, mw;
    logic [16:0] ma;
    int cyc, rc, wc;
    bit h;
    do_op(1'b0, a, 32'd0, srd, 2, 1'b0, rd, cyc, rc, wc, h, ma, mw);
    check_eq({tg, "_hit"}, {31'd0, h}, {31'd0, exp_hit});
    check_eq({tg, "_data"}, rd, exp_data);
    check_eq({tg, "_sram_rd"}, {31'd0, rc != 0}, {31'd0, !exp_hit});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, mw;
    logic [16:0] ma;
    int cyc, rc, wc;
    bit h, seen;

    repeat (2) @(negedge clk);
    check_eq("rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
    check_eq("rst_sram_rd", {31'd0, sram_rd}, 32'd0);
    check_eq("rst_sram_wr", {31'd0, sram_wr}, 32'd0);
    check_eq("rst_hit", {31'd0, hit}, 32'd0);
    check_eq("rst_rdata", cpu_rdata, 32'd0);
    check_eq("rst_sram_addr", {15'd0, sram_addr}, 32'd0);
    rst_n = 1'b1;

    // Cold miss on set 5 tag 1 with a 3-cycle SRAM, then a 2-cycle hit.
    do_op(1'b0, 17'h00085, 32'd0, 32'hDEADBEEF, 3, 1'b0, rd, cyc, rc, wc, h, ma, mw);
    check_eq("miss1_data", rd, 32'hDEADBEEF);
    check_eq("miss1_rd_cycles", rc, 32'd3);
    check_eq("miss1_hit", {31'd0, h}, 32'd0);
    check_eq("miss1_sram_addr", {15'd0, ma}, 32'h00085);
    do_op(1'b0, 17'h00085, 32'd0, 32'h0, 3, 1'b0, rd, cyc, rc, wc, h, ma, mw);
    check_eq("hit1_data", rd, 32'hDEADBEEF);
    check_eq("hit1_hit", {31'd0, h}, 32'd1);
    check_eq("hit1_rd_cycles", rc, 32'd0);
    check_eq("hit1_latency", cyc + 1, 32'd2);

    // Fill set 5: ways 0..3 hold tags 1..4, MRU saturates and restarts at 1000b.
    read_chk("t2_fill", 17'h00105, 32'hA2, 1'b0, 32'hA2);
    read_chk("t3_fill", 17'h00185, 32'hA3, 1'b0, 32'hA3);
    read_chk("t4_fill", 17'h00205, 32'hA4, 1'b0, 32'hA4);
    read_chk("t5_fill", 17'h00285, 32'hA5, 1'b0, 32'hA5);
    // Tag 5 replaced way 0 (tag 1); MRU 1001 -> tag 2 hit -> 1011.
    read_chk("t2_hit", 17'h00105, 32'h0, 1'b1, 32'hA2);
    // Tag 1 misses, victim way 2 (tag 3); MRU -> 0100.
    read_chk("t1_evicted", 17'h00085, 32'hB1, 1'b0, 32'hB1);
    // Tag 3 misses, victim way 0 (tag 5); MRU -> 0101.
    read_chk("t3_evicted", 17'h00185, 32'hC3, 1'b0, 32'hC3);
    read_chk("t4_hit", 17'h00205, 32'h0, 1'b1, 32'hA4);
    // Tag 5 misses, victim way 1 (tag 2); MRU -> 0010.
    read_chk("t5_evicted", 17'h00285, 32'hC5, 1'b0, 32'hC5);
    read_chk("t1_hit", 17'h00085, 32'h0, 1'b1, 32'hB1);

    // Write hit: write-through with sram_wr held 3 cycles, cache updated.
    do_op(1'b1, 17'h00085, 32'h12345678, 32'h0, 3, 1'b0, rd, cyc, rc, wc, h, ma, mw);
    check_eq("wrhit_hit", {31'd0, h}, 32'd1);
    check_eq("wrhit_wr_cycles", wc, 32'd3);
    check_eq("wrhit_rd_cycles", rc, 32'd0);
    check_eq("wrhit_sram_addr", {15'd0, ma}, 32'h00085);
    check_eq("wrhit_sram_wdata", mw, 32'h12345678);
    read_chk("wrhit_readback", 17'h00085, 32'h0, 1'b1, 32'h12345678);

    // Write miss on the top set with cpu_wr dropped early: completes, no allocation.
    do_op(1'b1, 17'h07F7F, 32'hCAFEF00D, 32'h0, 1, 1'b1, rd, cyc, rc, wc, h, ma, mw);
    check_eq("wrmiss_hit", {31'd0, h}, 32'd0);
    check_eq("wrmiss_wr_cycles", wc, 32'd1);
    check_eq("wrmiss_sram_wdata", mw, 32'hCAFEF00D);
    read_chk("wrmiss_noalloc", 17'h07F7F, 32'h0BADF00D, 1'b0, 32'h0BADF00D);
    read_chk("set7f_hit", 17'h07F7F, 32'h0, 1'b1, 32'h0BADF00D);
    read_chk("set0_miss", 17'h10000, 32'h5A5A0000, 1'b0, 32'h5A5A0000);
    read_chk("set0_hit", 17'h10000, 32'h0, 1'b1, 32'h5A5A0000);

    // Reset in the middle of a fill.
    @(negedge clk);
    cpu_rd = 1'b1; cpu_addr = 17'h00305;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      seen = sram_rd;
    end
    check_eq("rstfill_sram_rd_seen", {31'd0, seen}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rstfill_sram_rd_drop", {31'd0, sram_rd}, 32'd0);
    check_eq("rstfill_cpu_ready", {31'd0, cpu_ready}, 32'd0);
    cpu_rd = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    read_chk("post_rst_a", 17'h00085, 32'h11, 1'b0, 32'h11);
    read_chk("post_rst_b", 17'h00285, 32'h22, 1'b0, 32'h22);
    read_chk("post_rst_hit_a", 17'h00085, 32'h0, 1'b1, 32'h11);
    read_chk("post_rst_hit_b", 17'h00285, 32'h0, 1'b1, 32'h22);
    read_chk("post_rst_hit_c", 17'h00085, 32'h0, 1'b1, 32'h11);
`ifdef CACHE_PERF_CNT_EN
    check_eq("perf_hit_cnt", hit_cnt, 32'd3);
    check_eq("perf_miss_cnt", miss_cnt, 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_nway_ctrl.md
Name: cache_nway_ctrl

Overview:
- Parametrised N-way set-associative, write-through, no-write-allocate cache between the CPU load/store path and the SRAM memory controller.
- Generalises the fixed 4-way/17-bit controller in the following ways:
  - WAYS, set count, address width and data width are all parameters.
  - Registered request/ready handshake on both sides, so the CPU stalls on misses.
  - Reset-cleared valid bits.
  - Deterministic MRU-bit pseudo-LRU victim selection.

Parameters:
- WAYS, 4, number of ways; power of 2, range 2..8.
- SET_BITS, 7, log2 of the number of sets.
- ADDR_W, 17, word address width; TAG_W = ADDR_W - SET_BITS.
- DATA_W, 32, data word width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cpu_rd  in  1  read request; held until cpu_ready.
- cpu_wr  in  1  write request; held until cpu_ready; mutually exclusive with cpu_rd.
- cpu_addr  in  ADDR_W  word address: set = [SET_BITS-1:0], tag = upper bits.
- cpu_wdata  in  DATA_W  store data.
- cpu_rdata  out  DATA_W  load data; valid only while cpu_ready is high for a read.
- cpu_ready  out  1  one-cycle completion pulse.
- sram_rd  out  1  SRAM read request; held until sram_ready.
- sram_wr  out  1  SRAM write request; held until sram_ready.
- sram_addr  out  ADDR_W  latched request address.
- sram_wdata  out  DATA_W  latched store data.
- sram_rdata  in  DATA_W  SRAM read data; valid when sram_ready is high.
- sram_ready  in  1  SRAM completion pulse.
- hit  out  1  high in LOOKUP when the tag matches.

Behaviour:
- Storage: per way, per set: tag, valid and data arrays (synchronous write, combinational read), plus one MRU bit per way per set.
- Async reset clears all valid and MRU bits, the FSM goes to IDLE, and all outputs go to 0.
- Tag and data arrays are not reset.
- FSM states: IDLE, LOOKUP, FILL, WRITE.
- IDLE:
  - On cpu_rd or cpu_wr, latch addr, wdata and the rd/wr flag, then go to LOOKUP.
  - cpu_ready stays 0.
- LOOKUP:
  - hit_way[i] = valid[i][set] & (tag[i][set] == tag). At most one way can match by construction.
  - Read hit: cpu_rdata = data of the hit way, cpu_ready = 1, MRU update, go to IDLE. Total latency is 2 cycles.
  - Read miss: go to FILL.
  - Write (hit or miss): if hit, write cpu data into the hit way and update MRU. Then go to WRITE.
- FILL:
  - sram_rd = 1 until sram_ready.
  - On sram_ready, in the same cycle:
    - write sram_rdata into the victim way;
    - set that way's tag and valid = 1;
    - update MRU;
    - cpu_rdata = sram_rdata, cpu_ready = 1;
    - go to IDLE.
- WRITE:
  - sram_wr = 1 until sram_ready.
  - On sram_ready: cpu_ready = 1, go to IDLE.
  - A write miss never allocates a line.
- Victim selection:
  - First choice: the lowest-index way with valid = 0.
  - Otherwise: the lowest-index way with MRU = 0.
  - At least one way always has MRU = 0, by the MRU invariant below.
- MRU update for an accessed way w:
  - Set MRU[w].
  - If every other way's MRU is already 1, clear all of them in the same write.
  - Result: MRU is never all-ones.
- cpu_rd/cpu_wr deasserted mid-operation: the latched request still completes; cpu_ready still pulses.
- A new request is sampled only in IDLE. Back-to-back requests therefore get one IDLE cycle between them.
- Reset mid-FILL or mid-WRITE aborts immediately; sram_rd and sram_wr drop asynchronously.
- Set-index wrap: no arithmetic is done on the address. Sets 0 and 2^SET_BITS-1 behave identically to all other sets.

Optional Feature:
- Macro: CACHE_PERF_CNT_EN.
- When defined, add these outputs:
  - hit_cnt[31:0], incremented on each read or write hit in LOOKUP;
  - miss_cnt[31:0], incremented on each read or write miss in LOOKUP.
- Both counters wrap modulo 2^32, reset to 0 and are readable at any time.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package cache_pkg holds:
  - the state enum cache_state_e {IDLE, LOOKUP, FILL, WRITE};
  - the default widths;
  - the derived constant localparam TAG_W;
  - a function onehot_lowest_zero(), used for victim selection.
- Sub-module cache_way_array, instantiated WAYS times, holds one way's tag, valid and data arrays.
- The MRU bits and FSM remain in the top-level module.

Test Plan:
- Reset, then read 0x00085 with sram_rdata = 0xDEADBEEF after 3 cycles -> FILL holds sram_rd for 3 cycles; cpu_rdata = 0xDEADBEEF with cpu_ready; a repeat read hits with 2-cycle latency and no sram_rd.
- Fill set 5 with tags 1..4, then read tag 5 -> victim is way 0. Trace MRU: after the 4th fill the MRU bits clear to 1000b, and the tag-5 fill goes to way 0.
- Write 0x12345678 to a cached address -> sram_wr held until sram_ready; a subsequent read hits and returns 0x12345678.
- Write to an uncached address -> sram_wr asserted; a subsequent read misses, proving no allocation.
- Assert rst_n low during FILL -> sram_rd drops immediately; after reset every read misses.
- With CACHE_PERF_CNT_EN defined, run 3 hits and 2 misses -> hit_cnt = 3, miss_cnt = 2.
